// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared state encoding, vector width and default timing parameters
package gate_seq_pkg;
    localparam int VEC_W = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_AUTO_PERIOD = 8;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_AUTO   = 2'd2
    } state_t;
endpackage

// File: rtl/gate_input_sequencer_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stable-count debouncer and rising-edge press pulse
module btn_debounce
    import gate_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, rise_q, rise_d, differ, done;
    // count consecutive samples disagreeing with the debounced level; any agreeing sample restarts
    always_comb begin
        differ  = sync_q[1] ^ level_q;
        done    = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (!differ || done) ? '0 : cnt_q + 1'b1;
        level_d = done ? sync_q[1] : level_q;
        rise_d  = done & sync_q[1];
    end
    // synchroniser, counter, level and press pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end
    assign level      = level_q;
    assign rise_pulse = rise_q;
endmodule

// File: rtl/gate_input_sequencer.sv
// gate_input_sequencer: steps a 2-bit gate operand vector manually by button or automatically by prescaler
module gate_input_sequencer
    import gate_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step,
    input  logic       sw_auto,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       vec_valid,
    output logic       wrap
);
    localparam int PW = $clog2(AUTO_PERIOD);
    logic [1:0]       sw_sync_q;
    logic             auto_s, btn_level, btn_rise, press, advance, period_end;
    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             valid_q, valid_d, wrap_q, wrap_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (btn_step),
        .level      (btn_level),
        .rise_pulse (btn_rise)
    );

    assign auto_s = sw_sync_q[1];
    assign press  = btn_rise & btn_level;

    // mode FSM, prescaler and vector step; a mode change always suppresses the advance
    always_comb begin
        state_d    = state_q;
        advance    = 1'b0;
        presc_d    = '0;
        period_end = (presc_q == PW'(AUTO_PERIOD - 1));
        case (state_q)
            S_IDLE:   state_d = auto_s ? S_AUTO : (press ? S_MANUAL : S_IDLE);
            S_MANUAL: begin
                state_d = auto_s ? S_AUTO : S_MANUAL;
                advance = press & ~auto_s;
            end
            S_AUTO:   begin
                state_d = auto_s ? S_AUTO : S_MANUAL;
                advance = auto_s & period_end;
                presc_d = (auto_s && !period_end) ? presc_q + 1'b1 : '0;
            end
            default:  state_d = S_IDLE;
        endcase
        vec_d   = vec_q + VEC_W'(advance);
        valid_d = advance;
        wrap_d  = advance & (vec_q == '1);
    end

    // state, prescaler, mode synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync_q <= '0;
            state_q   <= S_IDLE;
            presc_q   <= '0;
            vec_q     <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            sw_sync_q <= {sw_sync_q[0], sw_auto};
            state_q   <= state_d;
            presc_q   <= presc_d;
            vec_q     <= vec_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign a         = vec_q[1];
    assign b         = vec_q[0];
    assign vec_idx   = vec_q;
    assign vec_valid = valid_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_gate_input_sequencer.sv
// tb_gate_input_sequencer: directed scenarios with DEBOUNCE_CYCLES=4, AUTO_PERIOD=3
module tb_gate_input_sequencer;
    import gate_seq_pkg::*;
    logic       clk = 1'b0, rst_n = 1'b1, btn_step = 1'b0, sw_auto = 1'b0;
    logic       a, b, vec_valid, wrap;
    logic [1:0] vec_idx;
    int         tests = 0, failed = 0;

    gate_input_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_step  (btn_step),
        .sw_auto   (sw_auto),
        .a         (a),
        .b         (b),
        .vec_idx   (vec_idx),
        .vec_valid (vec_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic press(output int nv, output int nw);
        nv = 0;
        nw = 0;
        btn_step = 1'b1;
        repeat (10) begin
            @(negedge clk);
            nv += int'(vec_valid);
            nw += int'(wrap);
        end
        btn_step = 1'b0;
        repeat (10) begin
            @(negedge clk);
            nv += int'(vec_valid);
            nw += int'(wrap);
        end
    endtask

    task automatic test_reset;
        int nv = 0;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if ({a, b, vec_idx, vec_valid, wrap} !== 6'b0) begin
            failed++;
            $display("FAIL reset_outputs: got %b, required 000000", {a, b, vec_idx, vec_valid, wrap});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            nv += int'(vec_valid);
        end
        tests++;
        if (nv !== 0) begin
            failed++;
            $display("FAIL idle_valid: got %0d pulses, required 0", nv);
        end
        tests++;
        if ({a, b} !== 2'b00) begin
            failed++;
            $display("FAIL idle_ab: got %b, required 00", {a, b});
        end
        tests++;
        if (dut.state_q !== S_IDLE) begin
            failed++;
            $display("FAIL idle_state: got %0d, required %0d", dut.state_q, S_IDLE);
        end
    endtask

    task automatic test_bounce;
        int nv = 0, nr = 0, nw;
        logic [3:0] pat = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            btn_step = pat[i];
            @(negedge clk);
            nv += int'(vec_valid);
            nr += int'(dut.u_deb.rise_pulse);
        end
        btn_step = 1'b1;
        repeat (10) begin
            @(negedge clk);
            nv += int'(vec_valid);
            nr += int'(dut.u_deb.rise_pulse);
        end
        btn_step = 1'b0;
        repeat (10) begin
            @(negedge clk);
            nv += int'(vec_valid);
            nr += int'(dut.u_deb.rise_pulse);
        end
        tests++;
        if (nr !== 1) begin
            failed++;
            $display("FAIL bounce_presses: got %0d, required 1", nr);
        end
        tests++;
        if (nv !== 0) begin
            failed++;
            $display("FAIL bounce_no_advance: got %0d pulses, required 0", nv);
        end
        tests++;
        if (dut.state_q !== S_MANUAL || vec_idx !== 2'b00) begin
            failed++;
            $display("FAIL bounce_state: got state %0d vec %b, required %0d vec 00", dut.state_q, vec_idx, S_MANUAL);
        end
        press(nv, nw);
        tests++;
        if (nv !== 1 || nw !== 0 || vec_idx !== 2'b01) begin
            failed++;
            $display("FAIL second_press: got valid %0d wrap %0d vec %b, required 1 0 01", nv, nw, vec_idx);
        end
    endtask

    task automatic test_manual_seq;
        int nv, nw;
        logic [1:0] exp_v [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        int exp_w [4] = '{0, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            press(nv, nw);
            tests++;
            if (vec_idx !== exp_v[i] || nv !== 1 || nw !== exp_w[i]) begin
                failed++;
                $display("FAIL manual_step%0d: got vec %b valid %0d wrap %0d, required vec %b valid 1 wrap %0d", i, vec_idx, nv, nw, exp_v[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_auto;
        int entry = -1, nr = 0;
        sw_auto  = 1'b1;
        btn_step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut.state_q == S_AUTO) begin
                entry = i;
                break;
            end
        end
        tests++;
        if (entry < 0) begin
            failed++;
            $display("FAIL auto_entry: got state %0d, required %0d within 10 cycles", dut.state_q, S_AUTO);
            return;
        end
        for (int off = 1; off <= 13; off++) begin
            @(negedge clk);
            nr += int'(dut.u_deb.rise_pulse);
            tests++;
            if (vec_valid !== (off % 3 == 0)) begin
                failed++;
                $display("FAIL auto_valid_off%0d: got %b, required %b", off, vec_valid, off % 3 == 0);
            end
            tests++;
            if (wrap !== (off == 9)) begin
                failed++;
                $display("FAIL auto_wrap_off%0d: got %b, required %b", off, wrap, off == 9);
            end
            if (off == 4) btn_step = 1'b0;
            if (off == 8) btn_step = 1'b1;
            if (off == 12) sw_auto = 1'b0;
        end
        tests++;
        if (nr !== 1 || vec_idx !== 2'b01) begin
            failed++;
            $display("FAIL auto_end: got presses %0d vec %b, required 1 and 01", nr, vec_idx);
        end
    endtask

    task automatic test_mode_change;
        @(negedge clk);
        tests++;
        if (dut.u_deb.rise_pulse !== 1'b1 || dut.sw_sync_q[1] !== 1'b0 || dut.state_q !== S_AUTO || dut.presc_q !== 2'd2) begin
            failed++;
            $display("FAIL collide_setup: got rise %b auto %b state %0d presc %0d, required 1 0 %0d 2", dut.u_deb.rise_pulse, dut.sw_sync_q[1], dut.state_q, dut.presc_q, S_AUTO);
        end
        @(negedge clk);
        tests++;
        if (dut.state_q !== S_MANUAL || dut.presc_q !== 2'd0 || vec_idx !== 2'b01 || vec_valid !== 1'b0) begin
            failed++;
            $display("FAIL collide_result: got state %0d presc %0d vec %b valid %b, required %0d 0 01 0", dut.state_q, dut.presc_q, vec_idx, vec_valid, S_MANUAL);
        end
        @(negedge clk);
        tests++;
        if (vec_idx !== 2'b01 || vec_valid !== 1'b0) begin
            failed++;
            $display("FAIL collide_hold: got vec %b valid %b, required 01 0", vec_idx, vec_valid);
        end
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_auto;
        int entry = -1;
        sw_auto = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut.state_q == S_AUTO) begin
                entry = i;
                break;
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (entry < 0 || vec_idx !== 2'b10) begin
            failed++;
            $display("FAIL pre_reset_vec: got entry %0d vec %b, required entry>=0 vec 10", entry, vec_idx);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({a, b, vec_idx, vec_valid, wrap} !== 6'b0 || dut.state_q !== S_IDLE || dut.presc_q !== 2'd0) begin
            failed++;
            $display("FAIL async_reset: got outs %b state %0d presc %0d, required 000000 %0d 0", {a, b, vec_idx, vec_valid, wrap}, dut.state_q, dut.presc_q, S_IDLE);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        entry = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut.state_q == S_AUTO) begin
                entry = i;
                break;
            end
        end
        tests++;
        if (entry < 0) begin
            failed++;
            $display("FAIL reentry: got state %0d, required %0d within 10 cycles", dut.state_q, S_AUTO);
            return;
        end
        for (int off = 1; off <= 3; off++) begin
            @(negedge clk);
            tests++;
            if (vec_valid !== (off == 3) || vec_idx !== ((off == 3) ? 2'b01 : 2'b00)) begin
                failed++;
                $display("FAIL reentry_off%0d: got valid %b vec %b, required %b %b", off, vec_valid, vec_idx, off == 3, (off == 3) ? 2'b01 : 2'b00);
            end
        end
    endtask

    initial begin
        test_reset;
        test_bounce;
        test_manual_seq;
        test_auto;
        test_mode_change;
        test_reset_mid_auto;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000");
        $fatal(1);
    end
endmodule
